// File: rtl/redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : redirect_ctrl
//  Purpose  : Sequences control-flow redirects from the EX-stage branch unit
//             into fetch. A taken branch / jalr target is captured, presented
//             to IF with a valid/ready handshake, and wrong-path instructions
//             are flushed for a programmable drain window. An illegal target
//             stops fetch permanently and raises a sticky trap.
//  Ports    : clk, reset (sync, active-low)
//             ex_valid, ex_pc_sel, ex_br_pc[31:0], stall_in  - EX branch info
//             fetch_ready                                     - IF accepts PC
//             redir_valid, redir_pc[PC_W-1:0]                 - redirect out
//             flush_ifid, flush_idex, fetch_hold              - pipe control
//             trap_err (sticky), redir_count[15:0] (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module redirect_ctrl #(
    parameter int PC_W      = 9,
    parameter int DRAIN_CYC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            ex_pc_sel,
    input  logic [31:0]     ex_br_pc,
    input  logic            stall_in,
    input  logic            fetch_ready,
    output logic            redir_valid,
    output logic [PC_W-1:0] redir_pc,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            fetch_hold,
    output logic            trap_err,
    output logic [15:0]     redir_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // drain_cnt counts the remaining DRAIN cycles minus one
    localparam logic [2:0] c_drain_init = (DRAIN_CYC > 0) ? 3'(DRAIN_CYC - 1) : 3'd0;
    localparam logic [PC_W-1:0] c_bit0_clr = ~{{(PC_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_drain_cnt;
    logic [PC_W-1:0] r_redir_pc;
    logic            r_trap;
    logic [15:0]     r_count;

    logic            w_capture;
    logic            w_legal;
    logic            w_handshake;

    // Bit 0 of the target is dropped (jalr semantics); bit 1 set means a
    // misaligned target, anything above the PC width is out of range.
    assign w_capture   = (r_state == ST_IDLE) && ex_valid && ex_pc_sel && !stall_in;
    assign w_legal     = ((ex_br_pc >> PC_W) == 32'd0) && !ex_br_pc[1];
    assign w_handshake = (r_state == ST_REQ) && fetch_ready;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = w_legal ? ST_REQ : ST_HALT;
                end
            end
            ST_REQ: begin
                if (fetch_ready) begin
                    w_state_nxt = (DRAIN_CYC > 0) ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == 3'd0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: purely from registered state, no input feed-through
    always_comb begin
        redir_valid = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        fetch_hold  = 1'b0;
        case (r_state)
            ST_REQ: begin
                redir_valid = 1'b1;
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
            end
            ST_DRAIN: begin
                flush_ifid  = 1'b1;
            end
            ST_HALT: begin
                fetch_hold  = 1'b1;
            end
            default: begin
                redir_valid = 1'b0;
            end
        endcase
    end

    assign redir_pc    = r_redir_pc;
    assign trap_err    = r_trap;
    assign redir_count = r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 3'd0;
            r_redir_pc  <= '0;
            r_trap      <= 1'b0;
            r_count     <= 16'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_capture && w_legal) begin
                r_redir_pc <= ex_br_pc[PC_W-1:0] & c_bit0_clr;
            end

            if (w_capture && !w_legal) begin
                r_trap <= 1'b1;
            end

            if (w_handshake && (r_count != 16'hFFFF)) begin
                r_count <= r_count + 16'd1;
            end

            if (w_handshake) begin
                r_drain_cnt <= c_drain_init;
            end else if ((r_state == ST_DRAIN) && (r_drain_cnt != 3'd0)) begin
                r_drain_cnt <= r_drain_cnt - 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_redirect_ctrl
//  Purpose  : Directed self-checking bench for redirect_ctrl. One instance
//             uses DRAIN_CYC=1, a second uses DRAIN_CYC=0; both share inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_redirect_ctrl;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_pc_sel;
    logic [31:0] ex_br_pc;
    logic        stall_in;
    logic        fetch_ready;

    logic        redir_valid, flush_ifid, flush_idex, fetch_hold, trap_err;
    logic [8:0]  redir_pc;
    logic [15:0] redir_count;

    logic        d0_redir_valid, d0_flush_ifid, d0_flush_idex, d0_fetch_hold, d0_trap_err;
    logic [8:0]  d0_redir_pc;
    logic [15:0] d0_redir_count;

    // {redir_valid, flush_ifid, flush_idex, fetch_hold, trap_err}
    logic [4:0]  w_ctl;
    logic [4:0]  w_d0_ctl;
    assign w_ctl    = {redir_valid, flush_ifid, flush_idex, fetch_hold, trap_err};
    assign w_d0_ctl = {d0_redir_valid, d0_flush_ifid, d0_flush_idex, d0_fetch_hold, d0_trap_err};

    int n_cmp;
    int n_err;

    redirect_ctrl #(.PC_W(9), .DRAIN_CYC(1)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_pc_sel   (ex_pc_sel),
        .ex_br_pc    (ex_br_pc),
        .stall_in    (stall_in),
        .fetch_ready (fetch_ready),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .fetch_hold  (fetch_hold),
        .trap_err    (trap_err),
        .redir_count (redir_count)
    );

    redirect_ctrl #(.PC_W(9), .DRAIN_CYC(0)) u_dut0 (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_pc_sel   (ex_pc_sel),
        .ex_br_pc    (ex_br_pc),
        .stall_in    (stall_in),
        .fetch_ready (fetch_ready),
        .redir_valid (d0_redir_valid),
        .redir_pc    (d0_redir_pc),
        .flush_ifid  (d0_flush_ifid),
        .flush_idex  (d0_flush_idex),
        .fetch_hold  (d0_fetch_hold),
        .trap_err    (d0_trap_err),
        .redir_count (d0_redir_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid    = 1'b0;
        ex_pc_sel   = 1'b0;
        ex_br_pc    = 32'd0;
        stall_in    = 1'b0;
        fetch_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic branch(input logic [31:0] tgt);
        ex_valid  = 1'b1;
        ex_pc_sel = 1'b1;
        ex_br_pc  = tgt;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        branch(32'h40);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (w_ctl !== 5'b00000 || redir_pc !== 9'h0 || redir_count !== 16'h0) begin
                n_err++;
                $display("FAIL reset_outputs cyc%0d: ctl=%b pc=%h cnt=%h, want ctl=00000 pc=000 cnt=0000",
                         i, w_ctl, redir_pc, redir_count);
            end
        end
        reset = 1'b1;
        tick();
        idle_inputs();
        n_cmp++;
        if (w_ctl !== 5'b11100 || redir_pc !== 9'h040) begin
            n_err++;
            $display("FAIL reset_release_capture: ctl=%b pc=%h, want ctl=11100 pc=040", w_ctl, redir_pc);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic();
        do_reset();
        branch(32'h40);
        fetch_ready = 1'b1;
        tick();
        ex_valid = 1'b0;
        n_cmp++;
        if (w_ctl !== 5'b11100 || redir_pc !== 9'h040 || redir_count !== 16'd0) begin
            n_err++;
            $display("FAIL basic_req: ctl=%b pc=%h cnt=%0d, want ctl=11100 pc=040 cnt=0", w_ctl, redir_pc, redir_count);
        end
        tick();
        n_cmp++;
        if (w_ctl !== 5'b01000 || redir_count !== 16'd1) begin
            n_err++;
            $display("FAIL basic_drain: ctl=%b cnt=%0d, want ctl=01000 cnt=1", w_ctl, redir_count);
        end
        tick();
        n_cmp++;
        if (w_ctl !== 5'b00000 || redir_count !== 16'd1 || redir_pc !== 9'h040) begin
            n_err++;
            $display("FAIL basic_idle: ctl=%b cnt=%0d pc=%h, want ctl=00000 cnt=1 pc=040", w_ctl, redir_count, redir_pc);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        do_reset();
        branch(32'h40);
        fetch_ready = 1'b0;
        tick();
        // A second branch arrives while the first is still being offered
        branch(32'h80);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) fetch_ready = 1'b1;
            n_cmp++;
            if (w_ctl !== 5'b11100 || redir_pc !== 9'h040 || redir_count !== 16'd0) begin
                n_err++;
                $display("FAIL bp_hold cyc%0d: ctl=%b pc=%h cnt=%0d, want ctl=11100 pc=040 cnt=0",
                         i, w_ctl, redir_pc, redir_count);
            end
            tick();
        end
        idle_inputs();
        n_cmp++;
        if (w_ctl !== 5'b01000 || redir_count !== 16'd1 || redir_pc !== 9'h040) begin
            n_err++;
            $display("FAIL bp_drain: ctl=%b cnt=%0d pc=%h, want ctl=01000 cnt=1 pc=040", w_ctl, redir_count, redir_pc);
        end
        tick();
        n_cmp++;
        if (w_ctl !== 5'b00000 || redir_count !== 16'd1) begin
            n_err++;
            $display("FAIL bp_idle: ctl=%b cnt=%0d, want ctl=00000 cnt=1", w_ctl, redir_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        do_reset();
        branch(32'h40);
        fetch_ready = 1'b1;
        tick();
        branch(32'h100);
        tick();
        n_cmp++;
        if (w_ctl !== 5'b01000) begin
            n_err++;
            $display("FAIL b2b_drain: ctl=%b, want 01000", w_ctl);
        end
        tick();
        n_cmp++;
        if (w_ctl !== 5'b00000 || redir_count !== 16'd1) begin
            n_err++;
            $display("FAIL b2b_idle: ctl=%b cnt=%0d, want ctl=00000 cnt=1", w_ctl, redir_count);
        end
        tick();
        ex_valid = 1'b0;
        n_cmp++;
        if (w_ctl !== 5'b11100 || redir_pc !== 9'h100) begin
            n_err++;
            $display("FAIL b2b_second_req: ctl=%b pc=%h, want ctl=11100 pc=100", w_ctl, redir_pc);
        end
        tick();
        tick();
        n_cmp++;
        if (w_ctl !== 5'b00000 || redir_count !== 16'd2) begin
            n_err++;
            $display("FAIL b2b_count: ctl=%b cnt=%0d, want ctl=00000 cnt=2", w_ctl, redir_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_jalr();
        do_reset();
        branch(32'h45);
        fetch_ready = 1'b1;
        tick();
        ex_valid = 1'b0;
        n_cmp++;
        if (w_ctl !== 5'b11100 || redir_pc !== 9'h044) begin
            n_err++;
            $display("FAIL jalr_bit0: ctl=%b pc=%h, want ctl=11100 pc=044", w_ctl, redir_pc);
        end
        tick();
        tick();
        // Misaligned target: trap, pc keeps the previous legal value
        branch(32'h46);
        tick();
        for (int i = 0; i < 20; i++) begin
            ex_valid    = 1'($urandom);
            ex_pc_sel   = 1'($urandom);
            ex_br_pc    = 32'($urandom_range(0, 511));
            stall_in    = 1'($urandom);
            fetch_ready = 1'($urandom);
            n_cmp++;
            if (w_ctl !== 5'b00011 || redir_pc !== 9'h044 || redir_count !== 16'd1) begin
                n_err++;
                $display("FAIL halt_hold cyc%0d: ctl=%b pc=%h cnt=%0d, want ctl=00011 pc=044 cnt=1",
                         i, w_ctl, redir_pc, redir_count);
            end
            tick();
        end
        do_reset();
        n_cmp++;
        if (w_ctl !== 5'b00000 || redir_pc !== 9'h0) begin
            n_err++;
            $display("FAIL halt_reset_clear: ctl=%b pc=%h, want ctl=00000 pc=000", w_ctl, redir_pc);
        end
        // Out of range for a 9-bit PC
        branch(32'h200);
        tick();
        idle_inputs();
        n_cmp++;
        if (w_ctl !== 5'b00011 || redir_pc !== 9'h0) begin
            n_err++;
            $display("FAIL halt_range: ctl=%b pc=%h, want ctl=00011 pc=000", w_ctl, redir_pc);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall_and_reset();
        do_reset();
        branch(32'h60);
        stall_in = 1'b1;
        tick();
        n_cmp++;
        if (w_ctl !== 5'b00000) begin
            n_err++;
            $display("FAIL stall_c1: ctl=%b, want 00000", w_ctl);
        end
        tick();
        n_cmp++;
        if (w_ctl !== 5'b00000) begin
            n_err++;
            $display("FAIL stall_c2: ctl=%b, want 00000", w_ctl);
        end
        stall_in = 1'b0;
        tick();
        idle_inputs();
        n_cmp++;
        if (w_ctl !== 5'b11100 || redir_pc !== 9'h060) begin
            n_err++;
            $display("FAIL stall_capture: ctl=%b pc=%h, want ctl=11100 pc=060", w_ctl, redir_pc);
        end
        // Reset while in REQ: in-flight redirect dropped, not counted
        reset       = 1'b0;
        fetch_ready = 1'b1;
        tick();
        reset = 1'b1;
        n_cmp++;
        if (w_ctl !== 5'b00000 || redir_count !== 16'd0 || redir_pc !== 9'h0) begin
            n_err++;
            $display("FAIL req_reset: ctl=%b cnt=%0d pc=%h, want ctl=00000 cnt=0 pc=000", w_ctl, redir_count, redir_pc);
        end
        tick();
        n_cmp++;
        if (w_ctl !== 5'b00000 || redir_count !== 16'd0) begin
            n_err++;
            $display("FAIL req_reset_idle: ctl=%b cnt=%0d, want ctl=00000 cnt=0", w_ctl, redir_count);
        end
        // Reset while in DRAIN
        branch(32'h20);
        tick();
        ex_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_cmp++;
        if (w_ctl !== 5'b00000 || redir_count !== 16'd0) begin
            n_err++;
            $display("FAIL drain_reset: ctl=%b cnt=%0d, want ctl=00000 cnt=0", w_ctl, redir_count);
        end
    endtask

    // ------------------------------------------------------------------
    // DRAIN_CYC=0 instance: each redirect occupies REQ + one IDLE cycle
    task automatic test_drain_zero();
        do_reset();
        branch(32'h40);
        fetch_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (w_d0_ctl !== ((i % 2 == 0) ? 5'b11100 : 5'b00000) ||
                d0_redir_count !== 16'((i + 1) / 2)) begin
                n_err++;
                $display("FAIL d0_seq cyc%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d", i, w_d0_ctl,
                         d0_redir_count, ((i % 2 == 0) ? 5'b11100 : 5'b00000), (i + 1) / 2);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_jalr();
        test_stall_and_reset();
        test_drain_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/redirect_ctrl.md
# redirect_ctrl

Sequences control-flow redirects from the EX-stage branch unit into fetch. It captures a taken branch or jalr (PcSel/BrPC), presents the redirect target to the IF stage with a valid/ready handshake, and flushes wrong-path instructions for a programmable drain window. It sits between the EX-stage branch logic and the PC register / IF-ID and ID-EX pipeline registers. Illegal targets stop fetch permanently and raise a sticky trap.

## Interface
- PC_W, 9: width of the instruction PC; legal targets satisfy br_pc[31:PC_W]==0.
- DRAIN_CYC, 1: extra IF/ID flush cycles after the handshake; legal range 0–7.

- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_pc_sel  in  1  branch taken or jalr (PcSel).
- ex_br_pc  in  32  redirect target (BrPC).
- stall_in  in  1  hazard stall; the EX instruction is re-presented next cycle.
- fetch_ready  in  1  IF accepts a new PC this cycle.
- redir_valid  out  1  redirect target is valid.
- redir_pc  out  PC_W  target, with bit 0 forced to 0.
- flush_ifid  out  1  kill the IF/ID register contents.
- flush_idex  out  1  kill the ID/EX register contents.
- fetch_hold  out  1  freeze the PC (HALT only).
- trap_err  out  1  sticky illegal-target flag.
- redir_count  out  16  accepted redirects, saturating.

## Operation
- States: IDLE, REQ, DRAIN, HALT. Reset enters IDLE.
- Capture condition: IDLE & ex_valid & ex_pc_sel & !stall_in.
  - Target is legal when ex_br_pc[31:PC_W]==0 and ex_br_pc[1]==0. Bit 0 is ignored, per jalr semantics.
  - Legal target: latch redir_pc = {ex_br_pc[PC_W-1:1],1'b0}, then go to REQ.
  - Illegal target: set trap_err, then go to HALT. redir_pc is unchanged.
- REQ:
  - Outputs: redir_valid=1, flush_ifid=1, flush_idex=1.
  - redir_pc stays stable until the handshake completes.
  - Handshake is redir_valid & fetch_ready. On handshake, redir_count increments, saturating at 0xFFFF.
  - Next state after handshake: DRAIN when DRAIN_CYC>0, loading drain_cnt=DRAIN_CYC-1; IDLE when DRAIN_CYC==0.
  - In REQ, all ex_* inputs and stall_in are ignored; those instructions are being flushed.
- DRAIN:
  - Outputs: flush_ifid=1, all others 0.
  - When drain_cnt==0 go to IDLE; otherwise decrement drain_cnt.
  - ex_* inputs are ignored.
- HALT:
  - Outputs: fetch_hold=1, trap_err=1, all other control outputs 0.
  - Exit only through reset.
- IDLE: redir_valid, flush_ifid, flush_idex and fetch_hold are all 0.
- Outputs are decoded from registered state only; no input-to-output combinational paths.
- Reset values: redir_valid=0, redir_pc=0, flush_ifid=0, flush_idex=0, fetch_hold=0, trap_err=0, redir_count=0, drain_cnt=0.

## Timing
- Capture on edge N gives redir_valid=1 and flushes during cycle N+1. Minimum latency from ex_pc_sel to redir_valid is 1 cycle.
- With fetch_ready=1 in cycle N+1:
  - DRAIN covers cycles N+2 … N+1+DRAIN_CYC.
  - IDLE begins at N+2+DRAIN_CYC. A new capture is possible from that cycle.
- Back-to-back redirect: a branch presented in the first IDLE cycle is captured that same cycle.
- ex_pc_sel together with stall_in=1: no capture in that cycle; capture happens on the first non-stalled cycle.
- Reset asserted in any state, including mid-REQ or mid-DRAIN: the next edge returns IDLE and all reset values. The in-flight redirect is dropped and is not counted.
- redir_count at 0xFFFF stays 0xFFFF on further handshakes.

## Test plan
- Reset: hold reset=0 for 2 cycles with ex_valid=ex_pc_sel=1 and ex_br_pc=0x40 -> all outputs 0 during reset; capture occurs on the first cycle after release.
- Basic branch, DRAIN_CYC=1, ex_br_pc=0x040, fetch_ready=1, capture at cycle N:
  - N+1: redir_valid=1, redir_pc=0x040, flush_ifid=flush_idex=1.
  - N+2: flush_ifid only.
  - N+3: idle, redir_count=1.
- Backpressure: fetch_ready=0 for 3 cycles, then 1; a second ex_pc_sel with target 0x080 arrives during REQ -> redir_valid high for 4 cycles, redir_pc stays 0x040, redir_count increments by 1 only.
- jalr targets:
  - ex_br_pc=0x00000045 -> redir_pc=0x044.
  - ex_br_pc=0x00000046 -> HALT with trap_err=1 and fetch_hold=1, held for 20 cycles under any inputs, cleared only by reset.
  - ex_br_pc=0x00000200 with PC_W=9 -> HALT.
- Stall and mid-operation reset:
  - ex_pc_sel=1 with stall_in=1 for 2 cycles, then 0 -> capture in the third cycle only.
  - reset=0 during REQ -> next cycle IDLE, redir_count unchanged.
- Saturation: DRAIN_CYC=0, 65540 back-to-back redirects -> redir_count=0xFFFF; each redirect occupies exactly 2 cycles.
